// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM arbiter: size codes, FSM encoding and
// the beat-count helper.
package mem_arbiter_pkg;

  localparam logic [1:0] SizeIllegal = 2'b00;
  localparam logic [1:0] SizeByte    = 2'b01;
  localparam logic [1:0] SizeHalf    = 2'b10;
  localparam logic [1:0] SizeWord    = 2'b11;

  localparam logic RstEnable = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_e;

  function automatic logic [2:0] size_beats(input logic [1:0] size);
    logic [2:0] beats;
    case (size)
      SizeByte: beats = 3'd1;
      SizeHalf: beats = 3'd2;
      SizeWord: beats = 3'd4;
      default:  beats = 3'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the MEM
// stage, sequencing little-endian byte beats and assembling read data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter bit MEM_PRIORITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  busy,
  input  logic [7:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr
);

  state_e                  state_r;
  logic [2:0]              cnt_r;
  logic [2:0]              beats_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [31:0]             wdata_r;
  logic [31:0]             rbuf_r;
  logic                    owner_mem_r;

  logic                    mem_ok_s;
  logic                    if_ok_s;
  logic                    grant_mem_s;
  logic                    grant_if_s;
  logic [31:0]             rbuf_nx_s;
  logic [7:0]              wbyte_s;

  // Request qualification, grant priority, read-lane merge and store byte select
  always_comb begin
    mem_ok_s    = mem_req && (mem_size != SizeIllegal);
    if_ok_s     = if_req && !if_flush;
    grant_mem_s = 1'b0;
    grant_if_s  = 1'b0;
    if (MEM_PRIORITY) begin
      grant_mem_s = mem_ok_s;
      grant_if_s  = if_ok_s && !mem_ok_s;
    end else begin
      grant_if_s  = if_ok_s;
      grant_mem_s = mem_ok_s && !if_ok_s;
    end

    // cnt_r==k+1 means the byte addressed on beat k is on ram_din now
    rbuf_nx_s = rbuf_r;
    case (cnt_r)
      3'd1:    rbuf_nx_s[7:0]   = ram_din;
      3'd2:    rbuf_nx_s[15:8]  = ram_din;
      3'd3:    rbuf_nx_s[23:16] = ram_din;
      3'd4:    rbuf_nx_s[31:24] = ram_din;
      default: rbuf_nx_s        = rbuf_r;
    endcase

    case (cnt_r[1:0])
      2'd0:    wbyte_s = wdata_r[7:0];
      2'd1:    wbyte_s = wdata_r[15:8];
      2'd2:    wbyte_s = wdata_r[23:16];
      default: wbyte_s = wdata_r[31:24];
    endcase
  end

  // Transfer FSM with beat counter and registered RAM/requester outputs
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      beats_r     <= 3'd0;
      addr_r      <= '0;
      wdata_r     <= 32'd0;
      rbuf_r      <= 32'd0;
      owner_mem_r <= 1'b0;
      if_data     <= 32'd0;
      if_done     <= 1'b0;
      mem_rdata   <= 32'd0;
      mem_done    <= 1'b0;
      busy        <= 1'b0;
      ram_a       <= '0;
      ram_dout    <= 8'd0;
      ram_wr      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_mem_s || grant_if_s) begin
            owner_mem_r <= grant_mem_s;
            addr_r      <= grant_mem_s ? mem_addr : if_addr;
            ram_a       <= grant_mem_s ? mem_addr : if_addr;
            beats_r     <= grant_mem_s ? size_beats(mem_size) : 3'd4;
            wdata_r     <= mem_wdata;
            rbuf_r      <= 32'd0;
            busy        <= 1'b1;
            if (grant_mem_s && mem_we) begin
              state_r  <= WRITE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              cnt_r    <= 3'd1;
            end else begin
              state_r  <= READ;
              ram_wr   <= 1'b0;
              cnt_r    <= 3'd0;
            end
          end else begin
            ram_wr <= 1'b0;
          end
        end
        READ: begin
          if (!owner_mem_r && if_flush) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= 3'd0;
          end else begin
            rbuf_r <= rbuf_nx_s;
            if (cnt_r == beats_r) begin
              state_r <= DONE;
              cnt_r   <= 3'd0;
              if (owner_mem_r) begin
                mem_rdata <= rbuf_nx_s;
                mem_done  <= 1'b1;
              end else begin
                if_data <= rbuf_nx_s;
                if_done <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + 3'd1;
              if ((cnt_r + 3'd1) < beats_r) begin
                ram_a <= addr_r + ADDR_WIDTH'(cnt_r + 3'd1);
              end else begin
                ram_a <= ram_a;
              end
            end
          end
        end
        WRITE: begin
          if (cnt_r == beats_r) begin
            ram_wr   <= 1'b0;
            state_r  <= DONE;
            mem_done <= 1'b1;
            cnt_r    <= 3'd0;
          end else begin
            ram_a    <= addr_r + ADDR_WIDTH'(cnt_r);
            ram_dout <= wbyte_s;
            cnt_r    <= cnt_r + 3'd1;
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 3'd0;
          busy     <= 1'b0;
          ram_wr   <= 1'b0;
          if_done  <= 1'b0;
          mem_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a byte-wide synchronous RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        busy;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;

  logic [7:0]  ram [0:4095];
  logic        tb_wr;
  logic [11:0] tb_wa;
  logic [7:0]  tb_wd;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] exp_if[$];
  logic [32:0] exp_mem[$];
  logic [19:0] wr_log[$];

  mem_arbiter #(.ADDR_WIDTH(32), .MEM_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
    .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: one-cycle read latency, synchronous write; tb_wr preloads contents
  always @(posedge clk) begin
    if (tb_wr) ram[tb_wa] <= tb_wd;
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected results on each done pulse; log RAM write beats
  always @(negedge clk) begin
    if (ram_wr) wr_log.push_back({ram_a[11:0], ram_dout});
    if (if_done) begin
      ncmp++;
      assert (exp_if.size() != 0) else begin
        nfail++;
        $error("FAIL unexpected_if_done: observed 1 expected 0");
      end
      if (exp_if.size() != 0) chk("if_data", if_data, exp_if.pop_front());
    end
    if (mem_done) begin
      ncmp++;
      assert (exp_mem.size() != 0) else begin
        nfail++;
        $error("FAIL unexpected_mem_done: observed 1 expected 0");
      end
      if (exp_mem.size() != 0) begin
        logic [32:0] e;
        e = exp_mem.pop_front();
        if (e[32]) chk("mem_rdata", mem_rdata, e[31:0]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    tick;
    tb_wr = 1'b0;
  endtask

  task automatic wait_done(input bit is_mem, input int maxc, output int cyc);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!(is_mem ? mem_done : if_done) && cyc < maxc);
    ncmp++;
    assert (is_mem ? mem_done : if_done) else begin
      nfail++;
      $error("FAIL done_timeout: observed 0 expected 1 within %0d cycles", maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'd0;
    mem_wdata = 32'd0; tb_wr = 1'b0; tb_wa = 12'd0; tb_wd = 8'd0;
    tick; tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    rst = 1'b1;

    poke(12'h100, 8'h13); poke(12'h101, 8'h00); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
    poke(12'h104, 8'h93); poke(12'h105, 8'h00); poke(12'h106, 8'h10); poke(12'h107, 8'h00);
    poke(12'h300, 8'h00); poke(12'h301, 8'h00); poke(12'h302, 8'h00); poke(12'h303, 8'h00);

    // 1: IF fetch, address sequence and done latency
    exp_if.push_back(32'h0000_0013);
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("t1_ram_a", ram_a, 32'h100 + k);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick;
    end
    chk("t1_early_done", {31'd0, if_done}, 32'd0);
    tick;
    chk("t1_if_done", {31'd0, if_done}, 32'd1);
    if_req = 1'b0;
    tick;
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_sb_empty", exp_if.size(), 32'd0);

    // 2: store word then half and word loads
    wr_log.delete();
    exp_mem.push_back({1'b0, 32'd0});
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b11; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    wait_done(1'b1, 20, cyc);
    chk("t2_store_cyc", cyc, 32'd5);
    chk("t2_ram_wr_off", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0;
    chk("t2_wr_count", wr_log.size(), 32'd4);
    if (wr_log.size() == 4) begin
      chk("t2_beat0", {12'd0, wr_log[0]}, {12'd0, 12'h200, 8'hEF});
      chk("t2_beat1", {12'd0, wr_log[1]}, {12'd0, 12'h201, 8'hBE});
      chk("t2_beat2", {12'd0, wr_log[2]}, {12'd0, 12'h202, 8'hAD});
      chk("t2_beat3", {12'd0, wr_log[3]}, {12'd0, 12'h203, 8'hDE});
    end
    tick;
    exp_mem.push_back({1'b1, 32'h0000_DEAD});
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h202;
    wait_done(1'b1, 20, cyc);
    chk("t2_half_cyc", cyc, 32'd4);
    mem_req = 1'b0;
    tick;
    exp_mem.push_back({1'b1, 32'hDEAD_BEEF});
    mem_req = 1'b1; mem_size = 2'b11; mem_addr = 32'h200;
    wait_done(1'b1, 20, cyc);
    chk("t2_word_cyc", cyc, 32'd6);
    mem_req = 1'b0;
    tick; tick;
    chk("t2_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
    chk("t2_sb_empty", exp_mem.size(), 32'd0);

    // 3: simultaneous requests, MEM wins, IF after turnaround
    exp_mem.push_back({1'b1, 32'h0000_00DE});
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'h203;
    wait_done(1'b1, 20, cyc);
    chk("t3_mem_cyc", cyc, 32'd3);
    mem_req = 1'b0;
    exp_if.push_back(32'h0000_0013);
    wait_done(1'b0, 20, cyc);
    chk("t3_if_cyc", cyc, 32'd7);
    if_req = 1'b0;
    tick;

    // 4: flush on second read beat, flush blocks idle grant, then refetch
    if_req = 1'b1; if_addr = 32'h100;
    tick;
    tick;
    chk("t4_beat2_addr", ram_a, 32'h101);
    if_flush = 1'b1;
    tick;
    chk("t4_flush_busy", {31'd0, busy}, 32'd0);
    tick; tick;
    chk("t4_flush_nogrant", {31'd0, busy}, 32'd0);
    chk("t4_no_if_done", {31'd0, if_done}, 32'd0);
    if_flush = 1'b0; if_addr = 32'h104;
    exp_if.push_back(32'h0010_0093);
    wait_done(1'b0, 20, cyc);
    chk("t4_refetch_cyc", cyc, 32'd6);
    if_req = 1'b0;
    tick;
    chk("t4_sb_empty", exp_if.size(), 32'd0);

    // 5: reset in the middle of a word store
    wr_log.delete();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b11; mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
    tick;
    tick;
    #2 rst = 1'b0;
    #1;
    chk("t5_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_ram_a", ram_a, 32'd0);
    chk("t5_ram_dout", {24'd0, ram_dout}, 32'd0);
    mem_req = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick; tick;
    chk("t5_wr_count", wr_log.size(), 32'd1);
    chk("t5_byte0", {24'd0, ram[12'h300]}, 32'h44);
    chk("t5_byte1", {24'd0, ram[12'h301]}, 32'h00);
    chk("t5_no_mem_done", exp_mem.size(), 32'd0);

    // 6: illegal size is never granted
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_ram_wr", {31'd0, ram_wr}, 32'd0);
    end
    mem_req = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
